// File: rtl/aftab_store_sequencer_if.sv
`default_nettype none
// ============================================================================
// aftab_store_sequencer_if : store request / byte-write bus bundle
// Revision: 1.0
// ============================================================================
interface aftab_store_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              startWr;
  logic [31:0]       dataIn;
  logic [ADDR_W-1:0] addrIn;
  logic [1:0]        nBytes;
  logic              memReady;
  logic [ADDR_W-1:0] addrOut;
  logic [7:0]        dataOut;
  logic              writeMem;
  logic [1:0]        laneSel;
  logic              laneEn;
  logic              busy;
  logic              completeWr;
  logic              misaligned;

  modport slave (
    input  startWr, dataIn, addrIn, nBytes, memReady,
    output addrOut, dataOut, writeMem, laneSel, laneEn, busy, completeWr, misaligned
  );

  modport master (
    output startWr, dataIn, addrIn, nBytes, memReady,
    input  addrOut, dataOut, writeMem, laneSel, laneEn, busy, completeWr, misaligned
  );
endinterface
`default_nettype wire

// File: rtl/aftab_store_sequencer.sv
`default_nettype none
// ============================================================================
// aftab_store_sequencer : splits a byte/half/word store into byte writes
// Revision: 1.0
// ============================================================================
module aftab_store_sequencer #(
  parameter int ADDR_W = 32
) (
  input  wire logic                clk,
  input  wire logic                rst,
  aftab_store_sequencer_if.slave   bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t            r_state;
  logic [31:0]       r_data;
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_last;
  logic [ADDR_W-1:0] r_addr_out;
  logic [7:0]        r_data_out;
  logic              r_write;
  logic [1:0]        r_lane;
  logic              r_busy;
  logic              r_complete;
  logic              r_misaligned;

  logic              w_reject;
  logic [1:0]        w_last_lane;
  logic [1:0]        w_next_lane;
  logic [ADDR_W-1:0] w_next_addr;
  logic [7:0]        w_next_byte;

  // Halfwords need even addresses, words need 4-byte alignment; code 10 is never legal.
  assign w_reject = (bus.nBytes == 2'b10) ||
                    ((bus.nBytes == 2'b01) && bus.addrIn[0]) ||
                    ((bus.nBytes == 2'b11) && (bus.addrIn[1:0] != 2'b00));

  always_comb begin
    w_last_lane = 2'd0;
    case (bus.nBytes)
      2'b01:   w_last_lane = 2'd1;
      2'b11:   w_last_lane = 2'd3;
      default: w_last_lane = 2'd0;
    endcase
  end

  assign w_next_lane = r_lane + 2'd1;
  assign w_next_addr = r_base + ADDR_W'(w_next_lane);
  assign w_next_byte = r_data[{w_next_lane, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_data       <= 32'd0;
      r_base       <= '0;
      r_last       <= 2'd0;
      r_addr_out   <= '0;
      r_data_out   <= 8'd0;
      r_write      <= 1'b0;
      r_lane       <= 2'd0;
      r_busy       <= 1'b0;
      r_complete   <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_complete   <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.startWr) begin
            if (w_reject) begin
              r_misaligned <= 1'b1;
            end else begin
              r_state    <= S_WRITE;
              r_data     <= bus.dataIn;
              r_base     <= bus.addrIn;
              r_last     <= w_last_lane;
              r_addr_out <= bus.addrIn;
              r_data_out <= bus.dataIn[7:0];
              r_write    <= 1'b1;
              r_lane     <= 2'd0;
              r_busy     <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          // Without memReady every output simply holds.
          if (bus.memReady) begin
            if (r_lane == r_last) begin
              r_state    <= S_IDLE;
              r_addr_out <= '0;
              r_data_out <= 8'd0;
              r_write    <= 1'b0;
              r_lane     <= 2'd0;
              r_busy     <= 1'b0;
              r_complete <= 1'b1;
            end else begin
              r_lane     <= w_next_lane;
              r_addr_out <= w_next_addr;
              r_data_out <= w_next_byte;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.addrOut    = r_addr_out;
  assign bus.dataOut    = r_data_out;
  assign bus.writeMem   = r_write;
  assign bus.laneEn     = r_write;
  assign bus.laneSel    = r_lane;
  assign bus.busy       = r_busy;
  assign bus.completeWr = r_complete;
  assign bus.misaligned = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_aftab_store_sequencer.sv
`default_nettype none
// ============================================================================
// tb_aftab_store_sequencer : directed and random checks against a write-queue model
// Revision: 1.0
// ============================================================================
module tb_aftab_store_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  aftab_store_sequencer_if #(.ADDR_W(32)) bus ();

  aftab_store_sequencer #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  b;
    logic [1:0]  lane;
  } wr_t;

  wr_t  q[$];
  logic exp_c;
  logic exp_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model by the store rules, compare every output.
  task automatic step(input logic r, input logic st, input logic [31:0] d,
                      input logic [31:0] a, input logic [1:0] nb, input logic rdy);
    int n;
    logic legal;
    @(negedge clk);
    rst = r;
    bus.startWr = st; bus.dataIn = d; bus.addrIn = a; bus.nBytes = nb; bus.memReady = rdy;
    @(posedge clk);
    #1;
    exp_c = 1'b0;
    exp_m = 1'b0;
    if (r) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (st) begin
        n = (nb == 2'b00) ? 1 : (nb == 2'b01) ? 2 : 4;
        legal = (nb != 2'b10) && ((a % n) == 0);
        if (legal) begin
          for (int i = 0; i < n; i++) begin
            wr_t w;
            w.addr = a + 32'(i);
            w.b    = 8'(d >> (8 * i));
            w.lane = 2'(i);
            q.push_back(w);
          end
        end else begin
          exp_m = 1'b1;
        end
      end
    end else if (rdy) begin
      void'(q.pop_front());
      if (q.size() == 0) exp_c = 1'b1;
    end
    chk("writeMem",   64'(bus.writeMem),   64'(q.size() != 0));
    chk("laneEn",     64'(bus.laneEn),     64'(q.size() != 0));
    chk("busy",       64'(bus.busy),       64'(q.size() != 0));
    chk("addrOut",    64'(bus.addrOut),    (q.size() != 0) ? 64'(q[0].addr) : 64'd0);
    chk("dataOut",    64'(bus.dataOut),    (q.size() != 0) ? 64'(q[0].b)    : 64'd0);
    chk("laneSel",    64'(bus.laneSel),    (q.size() != 0) ? 64'(q[0].lane) : 64'd0);
    chk("completeWr", 64'(bus.completeWr), 64'(exp_c));
    chk("misaligned", 64'(bus.misaligned), 64'(exp_m));
  endtask

  initial begin
    bus.startWr = 1'b0; bus.dataIn = '0; bus.addrIn = '0; bus.nBytes = 2'b00; bus.memReady = 1'b0;

    // Reset state
    step(1, 1, 32'hDEADBEEF, 32'h0, 2'b00, 1);
    step(0, 0, 32'h0, 32'h0, 2'b00, 1);

    // Aligned word store with memory always ready
    step(0, 1, 32'hA1B2C3D4, 32'h100, 2'b11, 1);
    repeat (5) step(0, 0, 32'h0, 32'h0, 2'b00, 1);

    // Halfword store stalled two cycles on the first byte
    step(0, 1, 32'h00005A6B, 32'h202, 2'b01, 0);
    step(0, 0, 32'h0, 32'h0, 2'b00, 0);
    step(0, 0, 32'h0, 32'h0, 2'b00, 0);
    repeat (3) step(0, 0, 32'h0, 32'h0, 2'b00, 1);

    // Rejected requests
    step(0, 1, 32'h11223344, 32'h101, 2'b11, 1);
    step(0, 0, 32'h0, 32'h0, 2'b00, 1);
    step(0, 1, 32'h11223344, 32'h100, 2'b10, 1);
    step(0, 1, 32'h11223344, 32'h203, 2'b01, 1);
    step(0, 0, 32'h0, 32'h0, 2'b00, 1);

    // New request during a busy word store is ignored
    step(0, 1, 32'h01020304, 32'h300, 2'b11, 1);
    step(0, 1, 32'hFFEEDDCC, 32'h404, 2'b11, 0);
    step(0, 1, 32'hFFEEDDCC, 32'h405, 2'b10, 1);
    repeat (4) step(0, 0, 32'h0, 32'h0, 2'b00, 1);

    // Reset in the middle of a word store, then a fresh byte store
    step(0, 1, 32'hCAFEF00D, 32'h500, 2'b11, 1);
    step(0, 0, 32'h0, 32'h0, 2'b00, 1);
    step(1, 1, 32'h12345678, 32'h0, 2'b00, 1);
    step(0, 0, 32'h0, 32'h0, 2'b00, 1);
    step(0, 1, 32'h000000EE, 32'h600, 2'b00, 1);
    step(0, 0, 32'h0, 32'h0, 2'b00, 1);
    step(0, 0, 32'h0, 32'h0, 2'b00, 1);

    // Byte store at top of memory, back-to-back request on the completion cycle
    step(0, 1, 32'h0000009C, 32'hFFFFFFFF, 2'b00, 1);
    step(0, 0, 32'h0, 32'h0, 2'b00, 1);
    step(0, 1, 32'h0000BEEF, 32'hFFFFFFFE, 2'b01, 1);
    repeat (3) step(0, 0, 32'h0, 32'h0, 2'b00, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
           $urandom(),
           $urandom(),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0);
    end
    step(0, 0, 32'h0, 32'h0, 2'b00, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aftab_store_sequencer.md
AFTAB_STORE_SEQUENCER -- requirements
Module: aftab_store_sequencer

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width of addrIn/addrOut.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: startWr  input  1  one-cycle store request; ignored unless idle.
REQ-005 Port: dataIn  input  32  store data; byte k = bits 8k+7:8k.
REQ-006 Port: addrIn  input  ADDR_W  store base byte address.
REQ-007 Port: nBytes  input  2  size code: 00 byte, 01 half, 11 word, 10 illegal.
REQ-008 Port: memReady  input  1  memory accepts current byte this cycle.
REQ-009 Port: addrOut  output  ADDR_W  byte address of current write.
REQ-010 Port: dataOut  output  8  byte being written.
REQ-011 Port: writeMem  output  1  byte-write strobe.
REQ-012 Port: laneSel  output  2  current byte-lane index; drives the 2-to-4 lane decoder dataIn.
REQ-013 Port: laneEn  output  1  decoder enable; SHALL equal writeMem every cycle.
REQ-014 Port: busy  output  1  high while a store is in progress.
REQ-015 Port: completeWr  output  1  one-cycle pulse after last byte accepted.
REQ-016 Port: misaligned  output  1  one-cycle pulse when a request is rejected.

Function
REQ-017 FSM SHALL have two states: IDLE and WRITE; all outputs registered.
REQ-018 In IDLE: writeMem=0, busy=0, laneSel=0, dataOut=0, addrOut=0.
REQ-019 startWr sampled in IDLE SHALL latch dataIn, addrIn, nBytes; last lane L = 0/1/3 for codes 00/01/11.
REQ-020 Reject when nBytes=10, nBytes=01 with addrIn[0]=1, or nBytes=11 with addrIn[1:0]!=00: stay IDLE, misaligned=1 for next cycle only, no write.
REQ-021 Accepted request: next cycle enter WRITE with busy=1, writeMem=1, laneSel=0, addrOut=base, dataOut=byte 0.
REQ-022 In WRITE with memReady=0: addrOut, dataOut, laneSel, writeMem SHALL hold unchanged.
REQ-023 In WRITE with memReady=1 and laneSel<L: next cycle laneSel+1, addrOut=base+laneSel+1 (mod 2^ADDR_W), dataOut=byte laneSel+1.
REQ-024 In WRITE with memReady=1 and laneSel=L: next cycle return to IDLE (REQ-018 values) and completeWr=1 for one cycle.
REQ-025 Latency: start accepted at edge k with memReady held high -> writeMem high cycles k+1..k+N (N=L+1), completeWr high cycle k+N+1; each memReady=0 cycle adds one.
REQ-026 startWr while busy SHALL be ignored; latched data/address unaffected; no misaligned pulse.
REQ-027 startWr in the cycle completeWr is high SHALL be accepted (back-to-back, zero bubble beyond IDLE cycle).
REQ-028 completeWr and misaligned SHALL never be high together; laneSel never exceeds L.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE and all outputs to 0, dominating startWr and memReady.
REQ-030 rst during WRITE SHALL abort the store: no further writeMem, no completeWr pulse.

Verification
REQ-031 Word store dataIn=0xA1B2C3D4, addrIn=0x100, memReady=1 -> 4 writes: (0x100,D4,lane0),(0x101,C3,1),(0x102,B2,2),(0x103,A1,3); completeWr next cycle.
REQ-032 Half store addrIn=0x202, memReady low 2 cycles on first byte -> (0x202,byte0) held 3 cycles, then (0x203,byte1); completeWr once.
REQ-033 Word store addrIn=0x101 -> misaligned=1 one cycle, writeMem never high, busy stays 0; same for nBytes=10 at any address.
REQ-034 startWr pulsed during busy with new data -> ignored; original bytes written unchanged.
REQ-035 rst asserted at second byte of word store -> next cycle all outputs 0, no completeWr; fresh byte store then completes in 2 cycles.
REQ-036 Byte store at addrIn=0xFFFFFFFF, then startWr during completeWr -> second store accepted immediately; laneEn mirrors writeMem throughout.
